// File: rtl/alu_sequencer_if.sv
// Command, ALU-drive and response signals of the ALU sequencer, bundled as one bus.
// slave = the sequencer; master = the command source, ALU and response consumer.
interface alu_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  logic [2:0] cmd_op;
  logic       cmd_cin;

  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_op;
  logic       alu_cin;
  logic       alu_init;
  logic       alu_done;
  logic [6:0] alu_result;
  logic       alu_carry;
  logic       alu_overflow;

  logic       rsp_valid;
  logic       rsp_ready;
  logic [6:0] rsp_result;
  logic [3:0] rsp_flags;

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, cmd_cin,
    input  alu_done, alu_result, alu_carry, alu_overflow,
    input  rsp_ready,
    output cmd_ready, alu_a, alu_b, alu_op, alu_cin, alu_init,
    output rsp_valid, rsp_result, rsp_flags
  );

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op, cmd_cin,
    output alu_done, alu_result, alu_carry, alu_overflow,
    output rsp_ready,
    input  cmd_ready, alu_a, alu_b, alu_op, alu_cin, alu_init,
    input  rsp_valid, rsp_result, rsp_flags
  );
endinterface

// File: rtl/alu_sequencer.sv
// Sequences one ALU operation per command: latch operands, strobe init, wait for done/settle, hold response.
// Optional RUN watchdog enabled by defining ALU_SEQ_TIMEOUT_EN.
module alu_sequencer #(
  parameter int INIT_CYCLES    = 2,
  parameter int SETTLE_CYCLES  = 1,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, INIT, RUN, RESP} state_t;

  // One shared counter serves INIT length, settle length and the watchdog.
  localparam int CNT_MAX_IS = (INIT_CYCLES > SETTLE_CYCLES) ? INIT_CYCLES : SETTLE_CYCLES;
  localparam int CNT_MAX    = (CNT_MAX_IS > TIMEOUT_CYCLES) ? CNT_MAX_IS : TIMEOUT_CYCLES;
  localparam int CNT_W      = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] INIT_LAST   = CNT_W'(INIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
`ifdef ALU_SEQ_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

  state_t           state_reg;
  state_t           state_next;
  logic [CNT_W-1:0] cnt_reg;

  logic [3:0] a_reg;
  logic [3:0] b_reg;
  logic [2:0] op_reg;
  logic       cin_reg;

  logic [6:0] result_reg;
  logic       carry_reg;
  logic       overflow_reg;
  logic       zero_reg;
`ifdef ALU_SEQ_TIMEOUT_EN
  logic       timeout_reg;
`endif

  logic accept;
  logic done_op;
  logic init_last;
  logic run_complete;
  logic run_timeout;
  logic rsp_handshake;

  logic cmd_ready_c;
  logic alu_init_c;
  logic rsp_valid_c;

  assign accept        = (state_reg == IDLE) && bus.cmd_valid;
  assign done_op       = op_reg inside {3'b010, 3'b011, 3'b111};
  assign init_last     = (state_reg == INIT) && (cnt_reg == INIT_LAST);
  assign rsp_handshake = (state_reg == RESP) && bus.rsp_ready;

  // Done-driven ops wait for alu_done; all others finish after a fixed settle time.
  assign run_complete = (state_reg == RUN) &&
                        (done_op ? bus.alu_done : (cnt_reg == SETTLE_LAST));

`ifdef ALU_SEQ_TIMEOUT_EN
  assign run_timeout = (state_reg == RUN) && !run_complete && (cnt_reg == TIMEOUT_LAST);
`else
  assign run_timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept)                      state_next = INIT;
      INIT: if (init_last)                   state_next = RUN;
      RUN:  if (run_complete || run_timeout) state_next = RESP;
      RESP: if (rsp_handshake)               state_next = IDLE;
      default:                               state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    cmd_ready_c = 1'b0;
    alu_init_c  = 1'b0;
    rsp_valid_c = 1'b0;
    case (state_reg)
      IDLE:    cmd_ready_c = 1'b1;
      INIT:    alu_init_c  = 1'b1;
      RESP:    rsp_valid_c = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (accept || init_last) begin
      cnt_reg <= '0;
    end else if ((state_reg == INIT) || (state_reg == RUN)) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  // Operands only move on acceptance, so they stay put through INIT/RUN/RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg   <= '0;
      b_reg   <= '0;
      op_reg  <= '0;
      cin_reg <= 1'b0;
    end else if (accept) begin
      a_reg   <= bus.cmd_a;
      b_reg   <= bus.cmd_b;
      op_reg  <= bus.cmd_op;
      cin_reg <= bus.cmd_cin;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_reg   <= '0;
      carry_reg    <= 1'b0;
      overflow_reg <= 1'b0;
      zero_reg     <= 1'b0;
`ifdef ALU_SEQ_TIMEOUT_EN
      timeout_reg  <= 1'b0;
`endif
    end else if (run_complete) begin
      result_reg   <= bus.alu_result;
      carry_reg    <= bus.alu_carry;
      overflow_reg <= bus.alu_overflow;
      zero_reg     <= (bus.alu_result == 7'd0);
`ifdef ALU_SEQ_TIMEOUT_EN
      timeout_reg  <= 1'b0;
    end else if (run_timeout) begin
      result_reg   <= '0;
      carry_reg    <= 1'b0;
      overflow_reg <= 1'b0;
      zero_reg     <= 1'b1;
      timeout_reg  <= 1'b1;
`endif
    end
  end

  assign bus.cmd_ready  = cmd_ready_c;
  assign bus.alu_init   = alu_init_c;
  assign bus.rsp_valid  = rsp_valid_c;
  assign bus.alu_a      = a_reg;
  assign bus.alu_b      = b_reg;
  assign bus.alu_op     = op_reg;
  assign bus.alu_cin    = cin_reg;
  assign bus.rsp_result = result_reg;
`ifdef ALU_SEQ_TIMEOUT_EN
  assign bus.rsp_flags  = {timeout_reg, zero_reg, overflow_reg, carry_reg};
`else
  assign bus.rsp_flags  = {1'b0, zero_reg, overflow_reg, carry_reg};
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: timestamp-based transaction model plus directed literal pins and random traffic.
`timescale 1ns/1ps
module tb_alu_sequencer;
  localparam int INIT_C    = 2;
  localparam int SETTLE_C  = 1;
  localparam int TIMEOUT_C = 64;
  localparam int NEVER     = 1 << 30;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_sequencer_if sif();

  alu_sequencer #(
    .INIT_CYCLES   (INIT_C),
    .SETTLE_CYCLES (SETTLE_C),
    .TIMEOUT_CYCLES(TIMEOUT_C)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (sif)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Model: a command accepted at edge m_acc answers at edge m_resp and leaves on handshake.
  bit         m_busy;
  int         m_acc, m_resp, m_k, m_rdy, last_hs;
  bit         m_to;
  logic [3:0] m_a, m_b;
  logic [2:0] m_op;
  logic       m_cin;
  logic [6:0] m_res;
  logic [3:0] m_flags;

  // Plan for the next accepted command (done delay, ready delay, fixed ALU outputs).
  int         p_k, p_rdy;
  bit         p_fix;
  logic [6:0] p_res;
  logic       p_c, p_v;

  int         obs_acc, obs_rise, obs_init;
  logic [6:0] obs_res;
  logic [3:0] obs_flags;
  bit         prev_valid;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=0x%0h expected=0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic bit is_settle(input logic [2:0] op);
    return !(op == 3'b010 || op == 3'b011 || op == 3'b111);
  endfunction

  task automatic rst_checks();
    chk("rst_cmd_ready", 32'(sif.cmd_ready), 32'd1);
    chk("rst_alu_init", 32'(sif.alu_init), 32'd0);
    chk("rst_rsp_valid", 32'(sif.rsp_valid), 32'd0);
    chk("rst_operands", 32'({sif.alu_a, sif.alu_b, sif.alu_op, sif.alu_cin}), 32'd0);
    chk("rst_rsp", 32'({sif.rsp_result, sif.rsp_flags}), 32'd0);
  endtask

  task automatic model_reset();
    m_busy = 0; m_resp = NEVER; m_acc = 0; m_to = 0;
    m_a = '0; m_b = '0; m_op = '0; m_cin = 1'b0;
    prev_valid = 0;
  endtask

  task automatic tick();
    int         e, run;
    bit         acc_now, cv, in_run;
    logic       d_rdy, d_c, d_v;
    logic [6:0] d_res;
    logic [3:0] ca, cb;
    logic [2:0] cop;
    logic       ccin;
    bit         exp_valid;

    e = cyc + 1;
    in_run = m_busy && (e > m_acc + INIT_C) && (e <= m_resp);
    if (in_run && !is_settle(m_op))
      sif.alu_done = (m_k > 0) && (e == m_acc + INIT_C + m_k);
    else
      sif.alu_done = 1'($urandom_range(0, 1));
    d_res = p_fix ? p_res : 7'($urandom);
    d_c   = p_fix ? p_c : 1'($urandom);
    d_v   = p_fix ? p_v : 1'($urandom);
    sif.alu_result = d_res; sif.alu_carry = d_c; sif.alu_overflow = d_v;
    if (m_busy && cyc >= m_resp) d_rdy = (cyc >= m_resp + m_rdy);
    else                         d_rdy = 1'($urandom_range(0, 1));
    sif.rsp_ready = d_rdy;

    cv = sif.cmd_valid; ca = sif.cmd_a; cb = sif.cmd_b; cop = sif.cmd_op; ccin = sif.cmd_cin;
    acc_now = sif.cmd_valid && sif.cmd_ready;
    @(posedge clk);
    cyc++;
    if (acc_now) obs_acc = cyc;

    if (m_busy) begin
      if (cyc == m_resp) begin
        m_res   = m_to ? 7'd0 : d_res;
        m_flags = m_to ? 4'b1100 : {1'b0, d_res == 7'd0, d_v, d_c};
      end else if (cyc > m_resp && d_rdy) begin
        m_busy = 0; last_hs = cyc;
      end
    end else if (cv) begin
      m_busy = 1; m_acc = cyc; m_to = 0;
      m_a = ca; m_b = cb; m_op = cop; m_cin = ccin;
      m_k = p_k; m_rdy = p_rdy;
      run = is_settle(cop) ? SETTLE_C : ((p_k > 0) ? p_k : NEVER);
`ifdef ALU_SEQ_TIMEOUT_EN
      if (run > TIMEOUT_C) begin run = TIMEOUT_C; m_to = 1; end
`endif
      m_resp = (run == NEVER) ? NEVER : cyc + INIT_C + run;
    end

    @(negedge clk);
    exp_valid = m_busy && (cyc >= m_resp);
    chk("cmd_ready", 32'(sif.cmd_ready), 32'(!m_busy));
    chk("alu_init", 32'(sif.alu_init), 32'(m_busy && (cyc < m_acc + INIT_C)));
    chk("rsp_valid", 32'(sif.rsp_valid), 32'(exp_valid));
    chk("alu_operands", 32'({sif.alu_a, sif.alu_b, sif.alu_op, sif.alu_cin}),
        32'({m_a, m_b, m_op, m_cin}));
    if (exp_valid) begin
      chk("rsp_result", 32'(sif.rsp_result), 32'(m_res));
      chk("rsp_flags", 32'(sif.rsp_flags), 32'(m_flags));
    end
    if (sif.alu_init) obs_init++;
    if (sif.rsp_valid && !prev_valid) begin
      obs_rise = cyc; obs_res = sif.rsp_result; obs_flags = sif.rsp_flags;
    end
    prev_valid = sif.rsp_valid;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    rst_checks();
    model_reset();
    sif.cmd_valid = 1'b0;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic directed(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                          input logic cin, input int k, input logic [6:0] res,
                          input logic c, input logic v, input int rdy, input bit tog,
                          input int max_cyc);
    p_fix = 1; p_res = res; p_c = c; p_v = v; p_k = k; p_rdy = rdy;
    sif.cmd_a = a; sif.cmd_b = b; sif.cmd_op = op; sif.cmd_cin = cin; sif.cmd_valid = 1'b1;
    obs_acc = -1; obs_rise = -1; obs_init = 0;
    for (int i = 0; i < max_cyc; i++) begin
      tick();
      if (obs_acc >= 0) begin
        if (!m_busy) break;
        // Toggle while busy, but hold high in RESP so the handshake edge sees a request.
        sif.cmd_valid = tog && (!sif.cmd_valid || cyc >= m_resp);
        sif.cmd_a = 4'($urandom); sif.cmd_b = 4'($urandom); sif.cmd_op = 3'($urandom);
      end
    end
    sif.cmd_valid = 1'b0;
    p_fix = 0;
  endtask

  initial begin
    int hs, rel;
    sif.cmd_valid = 1'b0; sif.cmd_a = '0; sif.cmd_b = '0; sif.cmd_op = '0; sif.cmd_cin = 1'b0;
    sif.alu_done = 1'b0; sif.alu_result = '0; sif.alu_carry = 1'b0; sif.alu_overflow = 1'b0;
    sif.rsp_ready = 1'b0;
    p_fix = 0; p_k = 1; p_rdy = 0; p_res = '0; p_c = 1'b0; p_v = 1'b0;
    obs_acc = -1; obs_rise = -1; obs_init = 0; last_hs = 0;
    model_reset();
    rst_n = 1'b0;
    #3;
    rst_checks();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;

    // add: 5+3 -> 0x08, first edge after reset accepts
    directed(4'd5, 4'd3, 3'b001, 1'b0, 0, 7'h08, 1'b0, 1'b0, 0, 0, 30);
    chk("first_accept_edge", 32'(obs_acc), 32'd1);
    chk("add_latency", 32'(obs_rise - obs_acc), 32'd3);
    chk("add_result", 32'(obs_res), 32'h08);
    chk("add_flags", 32'(obs_flags), 32'b0000);

    // mult: 15*15 done after 8 RUN cycles
    directed(4'hF, 4'hF, 3'b010, 1'b0, 8, 7'h61, 1'b0, 1'b1, 1, 0, 40);
    chk("mult_latency", 32'(obs_rise - obs_acc), 32'd10);
    chk("mult_result", 32'(obs_res), 32'h61);
    chk("mult_flags", 32'(obs_flags), 32'b0010);
    chk("mult_init_cycles", 32'(obs_init), 32'd2);

    // AND with zero result sets zero flag
    directed(4'hA, 4'h5, 3'b111, 1'b0, 3, 7'h00, 1'b0, 1'b0, 0, 0, 30);
    chk("and_result", 32'(obs_res), 32'h00);
    chk("and_flags", 32'(obs_flags), 32'b0100);

    // back-pressure: rsp_ready low 10 cycles while cmd_valid toggles
    directed(4'd3, 4'd4, 3'b011, 1'b1, 5, 7'h15, 1'b1, 1'b0, 10, 1, 60);
    chk("bp_result", 32'(obs_res), 32'h15);
    chk("bp_flags", 32'(obs_flags), 32'b0001);
    hs = last_hs;
    directed(4'd2, 4'd2, 3'b001, 1'b0, 0, 7'h04, 1'b0, 1'b0, 0, 0, 30);
    chk("accept_after_hs", 32'(obs_acc), 32'(hs + 1));

    // mult whose done never comes
`ifdef ALU_SEQ_TIMEOUT_EN
    directed(4'd6, 4'd7, 3'b010, 1'b0, 0, 7'h33, 1'b1, 1'b1, 0, 0, 200);
    chk("timeout_latency", 32'(obs_rise - obs_acc), 32'(INIT_C + TIMEOUT_C));
    chk("timeout_result", 32'(obs_res), 32'h00);
    chk("timeout_flags", 32'(obs_flags), 32'b1100);
`else
    directed(4'd6, 4'd7, 3'b010, 1'b0, 0, 7'h33, 1'b1, 1'b1, 0, 0, 1000);
    chk("no_timeout_rsp", 32'(obs_rise), 32'hFFFF_FFFF);
    do_reset();
`endif

    // reset during INIT, then a normal command
    sif.cmd_a = 4'd9; sif.cmd_b = 4'd9; sif.cmd_op = 3'b001; sif.cmd_cin = 1'b1; sif.cmd_valid = 1'b1;
    p_k = 0;
    tick();
    chk("init_before_rst", 32'(sif.alu_init), 32'd1);
    do_reset();
    rel = cyc;
    directed(4'd1, 4'd1, 3'b001, 1'b0, 0, 7'h02, 1'b0, 1'b0, 0, 0, 30);
    chk("post_rst_accept", 32'(obs_acc), 32'(rel + 1));
    chk("post_rst_latency", 32'(obs_rise - obs_acc), 32'd3);
    chk("post_rst_result", 32'(obs_res), 32'h02);

    // random traffic
    for (int i = 0; i < 2500; i++) begin
      sif.cmd_valid = ($urandom_range(0, 2) == 0);
      sif.cmd_a = 4'($urandom); sif.cmd_b = 4'($urandom);
      sif.cmd_op = 3'($urandom); sif.cmd_cin = 1'($urandom);
`ifdef ALU_SEQ_TIMEOUT_EN
      p_k = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 12));
`else
      p_k = int'($urandom_range(1, 12));
`endif
      p_rdy = int'($urandom_range(0, 4));
      tick();
      if (i == 900 || i == 1700) do_reset();
    end
    sif.cmd_valid = 1'b0;
    for (int i = 0; i < 200 && m_busy; i++) tick();
    chk("drain_idle", 32'(sif.cmd_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
